// File: rtl/routing_channel_cfg_pkg.sv
// Shared types and constant helpers for the routing channel: config FSM
// states, select-width derivation and the identity placement map.
package routing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } cfg_state_t;

  localparam int unsigned MAX_MAP_W = 1024;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Packed map with slot i selecting segment i; caller keeps the low n*sw bits.
  function automatic logic [MAX_MAP_W-1:0] identity_map(input int unsigned n,
                                                        input int unsigned sw);
    logic [MAX_MAP_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned b = 0; b < sw; b++) begin
        m[i*sw+b] = ((i >> b) & 1) != 0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/routing_channel_cfg_perm_check.sv
// Combinational permutation check: flags a packed select map as legal and
// returns its inverse (slot index for each segment).
module perm_check #(
  parameter int unsigned NUM_CLB = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic [NUM_CLB*SEL_W-1:0] map,
  output logic                     valid,
  output logic [NUM_CLB*SEL_W-1:0] inv
);

  logic [NUM_CLB-1:0] seen;
  logic [SEL_W-1:0]   s;

  always_comb begin
    valid = 1'b1;
    inv   = '0;
    seen  = '0;
    s     = '0;
    for (int unsigned i = 0; i < NUM_CLB; i++) begin
      s = map[i*SEL_W +: SEL_W];
      if (32'(s) >= NUM_CLB) begin
        valid = 1'b0;
      end else begin
        if (seen[s]) valid = 1'b0;
        seen[s] = 1'b1;
        inv[s*SEL_W +: SEL_W] = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/routing_channel_cfg.sv
// Permutable adder routing channel with serially loaded, checked placement map.
// Optional macro SUM_PIPE_EN registers sum_out/cout (1-cycle latency).
module routing_channel_cfg
  import routing_pkg::*;
#(
  parameter int unsigned NUM_CLB = 4,
  parameter int unsigned SLICE_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  input  logic                         cfg_bit,
  input  logic                         cfg_abort,
  output logic                         cfg_ready,
  output logic                         cfg_done,
  output logic                         cfg_err,
  input  logic [NUM_CLB*SLICE_W-1:0]   num_1,
  input  logic [NUM_CLB*SLICE_W-1:0]   num_2,
  input  logic                         carry_in,
  input  logic [NUM_CLB-1:0]           clb_carry,
  input  logic [NUM_CLB*SLICE_W-1:0]   clb_sum,
  output logic [NUM_CLB*SLICE_W-1:0]   clb_num_1,
  output logic [NUM_CLB*SLICE_W-1:0]   clb_num_2,
  output logic [NUM_CLB-1:0]           clb_cin,
  output logic [NUM_CLB*SLICE_W-1:0]   sum_out,
  output logic                         cout
);

  localparam int unsigned SEL_W   = sel_width(NUM_CLB);
  localparam int unsigned CFG_LEN = NUM_CLB * SEL_W;
  localparam int unsigned CNT_W   = $clog2(CFG_LEN + 1);
  localparam logic [MAX_MAP_W-1:0] ID_FULL = identity_map(NUM_CLB, SEL_W);
  localparam logic [CFG_LEN-1:0]   ID_MAP  = ID_FULL[CFG_LEN-1:0];

  cfg_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CFG_LEN-1:0] shadow, shadow_n;
  logic [CFG_LEN-1:0] map_q;
  logic               shadow_ok;
  logic [CFG_LEN-1:0] shadow_inv_unused;
  logic               act_ok_unused;
  logic [CFG_LEN-1:0] inv_act;

  perm_check #(.NUM_CLB(NUM_CLB), .SEL_W(SEL_W)) u_shadow_chk (
    .map   (shadow),
    .valid (shadow_ok),
    .inv   (shadow_inv_unused)
  );

  perm_check #(.NUM_CLB(NUM_CLB), .SEL_W(SEL_W)) u_active_inv (
    .map   (map_q),
    .valid (act_ok_unused),
    .inv   (inv_act)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      map_q    <= ID_MAP;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shadow   <= shadow_n;
      cfg_done <= (state == CHECK) && shadow_ok;
      cfg_err  <= (state == CHECK) && !shadow_ok;
      if (state == CHECK && shadow_ok) map_q <= shadow;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shadow_n  = shadow;
    cfg_ready = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_abort) begin
          cnt_n = '0;
        end else if (cfg_valid) begin
          shadow_n = {cfg_bit, shadow[CFG_LEN-1:1]};
          cnt_n    = CNT_W'(1);
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        if (cfg_abort) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cfg_valid) begin
          shadow_n = {cfg_bit, shadow[CFG_LEN-1:1]};
          cnt_n    = cnt + 1'b1;
          if (cnt_n == CNT_W'(CFG_LEN)) state_n = CHECK;
        end
      end
      CHECK: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  logic [SEL_W-1:0]             seg, prev, src;
  logic [NUM_CLB*SLICE_W-1:0]   sum_c;
  logic                         cout_c;

  // Carry of a slot comes from whichever slot holds the next-lower segment,
  // found through the inverse map so any permutation still ripples correctly.
  always_comb begin
    clb_num_1 = '0;
    clb_num_2 = '0;
    clb_cin   = '0;
    sum_c     = '0;
    seg       = '0;
    prev      = '0;
    src       = '0;
    for (int unsigned i = 0; i < NUM_CLB; i++) begin
      seg = map_q[i*SEL_W +: SEL_W];
      clb_num_1[i*SLICE_W +: SLICE_W] = num_1[seg*SLICE_W +: SLICE_W];
      clb_num_2[i*SLICE_W +: SLICE_W] = num_2[seg*SLICE_W +: SLICE_W];
      if (seg == '0) begin
        clb_cin[i] = carry_in;
      end else begin
        prev       = seg - 1'b1;
        clb_cin[i] = clb_carry[inv_act[prev*SEL_W +: SEL_W]];
      end
      src = inv_act[i*SEL_W +: SEL_W];
      sum_c[i*SLICE_W +: SLICE_W] = clb_sum[src*SLICE_W +: SLICE_W];
    end
    cout_c = clb_carry[inv_act[(NUM_CLB-1)*SEL_W +: SEL_W]];
  end

`ifdef SUM_PIPE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      sum_out <= sum_c;
      cout    <= cout_c;
    end
  end
`else
  always_comb begin
    sum_out = sum_c;
    cout    = cout_c;
  end
`endif

endmodule

// File: tb/tb_routing_channel_cfg.sv
// Bench for routing_channel_cfg: behavioural 2-bit CLB adders, vector table
// with a result scoreboard, and hand-written config-frame sequences.
module tb_routing_channel_cfg;

  localparam int unsigned NUM = 4;
  localparam int unsigned SW  = 2;

  logic       clk;
  logic       rst;
  logic       cfg_valid, cfg_bit, cfg_abort;
  logic       cfg_ready, cfg_done, cfg_err;
  logic [7:0] num_1, num_2;
  logic       carry_in;
  logic [3:0] clb_carry;
  logic [7:0] clb_sum;
  logic [7:0] clb_num_1, clb_num_2;
  logic [3:0] clb_cin;
  logic [7:0] sum_out;
  logic       cout;

  routing_channel_cfg #(.NUM_CLB(NUM), .SLICE_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .num_1     (num_1),
    .num_2     (num_2),
    .carry_in  (carry_in),
    .clb_carry (clb_carry),
    .clb_sum   (clb_sum),
    .clb_num_1 (clb_num_1),
    .clb_num_2 (clb_num_2),
    .clb_cin   (clb_cin),
    .sum_out   (sum_out),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
  } res_t;

  vec_t vecs [8];
  res_t sb [$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Iterate the CLB adders until the ripple through the routed carries settles.
  task automatic settle();
    logic [2:0] r;
    for (int k = 0; k <= int'(NUM); k++) begin
      for (int i = 0; i < int'(NUM); i++) begin
        r = {1'b0, clb_num_1[i*2 +: 2]} + {1'b0, clb_num_2[i*2 +: 2]} + {2'b00, clb_cin[i]};
        clb_sum[i*2 +: 2] = r[1:0];
        clb_carry[i]      = r[2];
      end
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    res_t r;
    num_1    = v.a;
    num_2    = v.b;
    carry_in = v.cin;
    r.s  = v.s;
    r.co = v.co;
    sb.push_back(r);
    settle();
`ifdef SUM_PIPE_EN
    step();
    settle();
`endif
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      r = sb.pop_front();
      chk({tag, "_sum"}, 32'(sum_out), 32'(r.s));
      chk({tag, "_cout"}, 32'(cout), 32'(r.co));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Eight beats LSB first, one CHECK cycle, then the pulse cycle.
  task automatic send_frame(input logic [7:0] frame, input logic ok,
                            input logic [7:0] exp_r1, input logic hold,
                            input string tag);
    num_1 = 8'hB4;
    for (int k = 0; k < 8; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = frame[k];
      if (k == 0) chk({tag, "_ready_first"}, 32'(cfg_ready), 32'd1);
      step();
    end
    chk({tag, "_check_ready"}, 32'(cfg_ready), 32'd0);
    chk({tag, "_check_nopulse"}, 32'(cfg_done | cfg_err), 32'd0);
    if (hold) cfg_bit = 1'b1;
    else cfg_valid = 1'b0;
    step();
    cfg_valid = 1'b0;
    chk({tag, "_done"}, 32'(cfg_done), 32'(ok));
    chk({tag, "_err"}, 32'(cfg_err), 32'(!ok));
    chk({tag, "_route"}, 32'(clb_num_1), 32'(exp_r1));
    step();
    chk({tag, "_pulse_end"}, 32'(cfg_done | cfg_err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hB4, 8'h3C, 1'b0, 8'hF0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    rst = 1'b1; cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
    num_1 = '0; num_2 = '0; carry_in = 1'b0; clb_carry = '0; clb_sum = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state and identity routing
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    num_1 = 8'hB4;
    settle();
    chk("id_route", 32'(clb_num_1), 32'h0000_00B4);
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("id%0d", i));

    // Reversed placement 8'h1B
    send_frame(8'h1B, 1'b1, 8'h1E, 1'b0, "rev");
    run_vec(vecs[1], "rev_ffp1");
    chk("rev_cin_chain", 32'(clb_cin), 32'h7);
    num_1 = 8'h00; num_2 = 8'h00; carry_in = 1'b1;
    settle();
    chk("rev_cin_slot3", 32'(clb_cin), 32'h8);
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("rev%0d", i));

    // Rejected frames leave the map alone
    do_reset();
    send_frame(8'h00, 1'b0, 8'hB4, 1'b0, "err00");
    run_vec(vecs[0], "err_s1");
    send_frame(8'hE5, 1'b0, 8'hB4, 1'b0, "errE5");

    // Abort after 5 beats; abort beats a same-cycle valid
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      step();
    end
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_quiet%0d", k), 32'({cfg_ready, cfg_done, cfg_err}), 32'h4);
      step();
    end
    send_frame(8'h1B, 1'b1, 8'h1E, 1'b0, "post_abort");

    // Reset mid-frame after a commit
    for (int k = 0; k < 3; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      step();
    end
    do_reset();
    num_1 = 8'hB4;
    settle();
    chk("midrst_ready", 32'(cfg_ready), 32'd1);
    chk("midrst_done", 32'(cfg_done | cfg_err), 32'd0);
    chk("midrst_route", 32'(clb_num_1), 32'h0000_00B4);
    send_frame(8'h1B, 1'b1, 8'h1E, 1'b0, "post_rst");

    // Valid held high through CHECK is ignored
    send_frame(8'h1B, 1'b1, 8'h1E, 1'b1, "hold");
    send_frame(8'hE4, 1'b1, 8'hB4, 1'b0, "after_hold");
    run_vec(vecs[3], "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
